// File: rtl/dmem_byte_initiator.sv
// Byte-serial load/store initiator between the MEM stage and a byte-wide
// data memory: one request becomes 1, 2 or 4 byte beats, then one response.
module dmem_byte_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_ctrl_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                  state;
    logic                    write_q;
    logic                    zext_q;
    logic                    err_q;
    logic [1:0]              size_q;
    logic [1:0]              beat_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   asm_q;
    logic                    last_beat;
    logic                    access;
    logic                    resp;
    logic [4:0]              lane;

    // Final beat index is 0, 1 or 3 for byte, half and word.
    assign last_beat = (beat_q == {size_q[1], |size_q});
    assign access    = (state == ACCESS);
    assign resp      = (state == RESP);
    assign lane      = {beat_q, 3'b000};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            write_q <= 1'b0;
            zext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            beat_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        zext_q  <= req_ctrl_i[2];
                        size_q  <= req_ctrl_i[1:0];
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        beat_q  <= 2'b00;
                        asm_q   <= '0;
                        err_q   <= &req_ctrl_i[1:0];
                        state   <= (&req_ctrl_i[1:0]) ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        asm_q[lane +: 8] <= mem_rdata_i;
                    end
                    beat_q <= beat_q + 2'd1;
                    if (last_beat) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = resp;
    assign rsp_err_o   = resp & err_q;
    assign mem_read_o  = access & ~write_q;
    assign mem_write_o = access & write_q;
    assign mem_addr_o  = access ? addr_q + ADDR_WIDTH'(beat_q) : '0;
    assign mem_wdata_o = mem_write_o ? wdata_q[lane +: 8] : 8'h00;

    always_comb begin
        rsp_rdata_o = '0;
        if (resp && !write_q && !err_q) begin
            case (size_q)
                2'b00: rsp_rdata_o = zext_q ? {24'b0, asm_q[7:0]}
                                            : {{24{asm_q[7]}}, asm_q[7:0]};
                2'b01: rsp_rdata_o = zext_q ? {16'b0, asm_q[15:0]}
                                            : {{16{asm_q[15]}}, asm_q[15:0]};
                default: rsp_rdata_o = asm_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_byte_initiator.sv
// Randomised bench for dmem_byte_initiator: a byte-array memory on the port
// and a separate byte-array reference model that predicts every response.
module tb_dmem_byte_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_ctrl;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit [7:0] mem [bit [31:0]];
    bit [7:0] ref_mem [bit [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wbeat_t;
    wbeat_t wq[$];

    always #5 clk = ~clk;

    dmem_byte_initiator dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ctrl_i  (req_ctrl),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Environment memory: writes land at the posedge, reads settle mid-cycle.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            wq.push_back('{mem_addr, mem_wdata, cyc});
        end
        cyc++;
    end

    always @(negedge clk) begin
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
        if (rst_n) begin
            total++;
            if ((mem_read && mem_write) ||
                ((mem_read || mem_write) && (req_ready || rsp_valid))) begin
                bad++;
                $display("FAIL strobe_rule: rd=%0b wr=%0b ready=%0b rsp_valid=%0b, required no strobe",
                         mem_read, mem_write, req_ready, rsp_valid);
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    function automatic bit [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Architectural load/store semantics over a byte array.
    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] c, output logic [31:0] rd,
                         output logic er, output int n);
        logic [31:0] val;
        logic [31:0] mask;
        er  = (c[1:0] == 2'b11);
        n   = er ? 0 : (1 << c[1:0]);
        rd  = 32'h0;
        val = 32'h0;
        if (!er && w) begin
            for (int b = 0; b < n; b++) ref_mem[32'(a + b)] = d[8*b +: 8];
        end else if (!er) begin
            for (int b = 0; b < n; b++) val = val | (32'(ref_rd(32'(a + b))) << (8 * b));
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            if (n < 4 && !c[2] && val[8*n-1]) val = val | ~mask;
            rd = val;
        end
    endtask

    // Drives one request from a negedge; returns at a negedge after the response.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] c, output logic [31:0] rd,
                          output logic er, output int lat, output int k);
        int n = 0;
        req_write = w; req_addr = a; req_wdata = d; req_ctrl = c; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
        end
        @(negedge clk);
        k = cyc;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom;     req_ctrl = 3'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=0, required 1");
            lat = -1;
        end
        if (rsp_ready) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 10000",
                     {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
        end
        total++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 72'h0) begin
            bad++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word;
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat, k, n;
        wq.delete();
        model(1'b1, 32'h1_0000, 32'hDEAD_BEEF, 3'b010, exp_rd, exp_er, n);
        do_txn(1'b1, 32'h1_0000, 32'hDEAD_BEEF, 3'b010, rd, er, lat, k);
        total++;
        if (wq.size() != 4) begin
            bad++;
            $display("FAIL sw_beats: got %0d beats, required 4", wq.size());
        end
        for (int b = 0; b < 4 && b < wq.size(); b++) begin
            total++;
            if (wq[b].addr !== 32'h1_0000 + b || wq[b].data !== 8'(32'hDEAD_BEEF >> (8 * b))
                || wq[b].cyc != k + b) begin
                bad++;
                $display("FAIL sw_beat%0d: addr=%h data=%h cyc=%0d, required %h %h %0d",
                         b, wq[b].addr, wq[b].data, wq[b].cyc,
                         32'h1_0000 + b, 8'(32'hDEAD_BEEF >> (8 * b)), k + b);
            end
        end
        total++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 4) begin
            bad++;
            $display("FAIL sw_rsp: rdata=%h err=%0b lat=%0d, required 0 0 4", rd, er, lat);
        end
        model(1'b0, 32'h1_0000, 32'h0, 3'b010, exp_rd, exp_er, n);
        do_txn(1'b0, 32'h1_0000, 32'h0, 3'b010, rd, er, lat, k);
        total++;
        if (rd !== 32'hDEAD_BEEF || rd !== exp_rd || er !== 1'b0 || lat != 4) begin
            bad++;
            $display("FAIL lw_rsp: rdata=%h err=%0b lat=%0d, required deadbeef 0 4", rd, er, lat);
        end
    endtask

    task automatic test_byte_ext;
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat, k, n;
        poke(32'h1_0005, 8'h80);
        model(1'b0, 32'h1_0005, 32'h0, 3'b000, exp_rd, exp_er, n);
        do_txn(1'b0, 32'h1_0005, 32'h0, 3'b000, rd, er, lat, k);
        total++;
        if (rd !== 32'hFFFF_FF80 || rd !== exp_rd || lat != 1) begin
            bad++;
            $display("FAIL lb: rdata=%h lat=%0d, required ffffff80 1", rd, lat);
        end
        model(1'b0, 32'h1_0005, 32'h0, 3'b100, exp_rd, exp_er, n);
        do_txn(1'b0, 32'h1_0005, 32'h0, 3'b100, rd, er, lat, k);
        total++;
        if (rd !== 32'h0000_0080 || rd !== exp_rd || lat != 1) begin
            bad++;
            $display("FAIL lbu: rdata=%h lat=%0d, required 00000080 1", rd, lat);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat, k, n;
        wq.delete();
        model(1'b1, 32'hFFFF_FFFF, 32'h0000_A55A, 3'b001, exp_rd, exp_er, n);
        do_txn(1'b1, 32'hFFFF_FFFF, 32'h0000_A55A, 3'b001, rd, er, lat, k);
        total++;
        if (wq.size() != 2 || wq[0].addr !== 32'hFFFF_FFFF || wq[0].data !== 8'h5A
            || wq[1].addr !== 32'h0 || wq[1].data !== 8'hA5) begin
            bad++;
            $display("FAIL sh_wrap_beats: n=%0d, required 2 beats ffffffff:5a 00000000:a5",
                     wq.size());
        end
        model(1'b0, 32'hFFFF_FFFF, 32'h0, 3'b001, exp_rd, exp_er, n);
        do_txn(1'b0, 32'hFFFF_FFFF, 32'h0, 3'b001, rd, er, lat, k);
        total++;
        if (rd !== 32'hFFFF_A55A || rd !== exp_rd || lat != 2) begin
            bad++;
            $display("FAIL lh_wrap: rdata=%h lat=%0d, required ffffa55a 2", rd, lat);
        end
    endtask

    task automatic test_illegal;
        wq.delete();
        rsp_ready = 1'b0;
        req_write = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_ctrl = 3'b011; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({rsp_valid, rsp_err, req_ready} !== 3'b110 || rsp_rdata !== 32'h0) begin
                bad++;
                $display("FAIL illegal_hold%0d: valid/err/ready=%b rdata=%h, required 110 0",
                         i, {rsp_valid, rsp_err, req_ready}, rsp_rdata);
            end
            if (i < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wq.size() != 0) begin
            bad++;
            $display("FAIL illegal_done: valid=%0b ready=%0b beats=%0d, required 0 1 0",
                     rsp_valid, req_ready, wq.size());
        end
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat, k, n, seen;
        for (int i = 0; i < 4; i++) poke(32'h3000 + i, 8'h00);
        req_write = 1'b1; req_addr = 32'h3000; req_wdata = 32'h1122_3344;
        req_ctrl = 3'b010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_write !== 1'b1 || mem_addr !== 32'h3002) begin
            bad++;
            $display("FAIL mid_store_beat2: wr=%0b addr=%h, required 1 00003002",
                     mem_write, mem_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000
            || {rsp_rdata, mem_addr, mem_wdata} !== 72'h0) begin
            bad++;
            $display("FAIL mid_store_reset_out: ctrl=%b addr=%h, required 10000 0",
                     {req_ready, rsp_valid, rsp_err, mem_read, mem_write}, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[32'h3000] = 8'h44;
        ref_mem[32'h3001] = 8'h33;
        total++;
        if (mem[32'h3000] !== 8'h44 || mem[32'h3001] !== 8'h33
            || mem[32'h3002] !== 8'h00 || mem[32'h3003] !== 8'h00) begin
            bad++;
            $display("FAIL mid_store_mem: %h %h %h %h, required 44 33 00 00",
                     mem[32'h3000], mem[32'h3001], mem[32'h3002], mem[32'h3003]);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_store_no_rsp: %0d response cycles, required 0", seen);
        end
        model(1'b0, 32'h3000, 32'h0, 3'b010, exp_rd, exp_er, n);
        do_txn(1'b0, 32'h3000, 32'h0, 3'b010, rd, er, lat, k);
        total++;
        if (rd !== 32'h0000_3344 || rd !== exp_rd || lat != 4) begin
            bad++;
            $display("FAIL after_reset_lw: rdata=%h lat=%0d, required 00003344 4", rd, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, exp_rd, a, d;
        logic [2:0] c;
        logic er, exp_er;
        bit w;
        int lat, k, n, prev_k, prev_n;
        for (int i = 0; i < 24; i++) poke(32'h2000 + i, 8'($urandom));
        for (int i = 0; i < 8; i++) poke(32'hFFFF_FFF8 + i, 8'($urandom));
        for (int i = 0; i < 8; i++) poke(32'h0 + i, 8'($urandom));
        prev_k = 0;
        prev_n = 0;
        for (int i = 0; i < 100; i++) begin
            w = 1'($urandom);
            c = {1'($urandom), ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2))};
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                            : 32'h2000 + $urandom_range(0, 19);
            d = $urandom;
            wq.delete();
            model(w, a, d, c, exp_rd, exp_er, n);
            do_txn(w, a, d, c, rd, er, lat, k);
            total++;
            if (rd !== exp_rd || er !== exp_er || lat != n || (w && !exp_er && wq.size() != n)) begin
                bad++;
                $display("FAIL b2b_rsp%0d: w=%0b a=%h c=%b rdata=%h err=%0b lat=%0d beats=%0d, required %h %0b %0d",
                         i, w, a, c, rd, er, lat, wq.size(), exp_rd, exp_er, n);
            end
            if (i > 0) begin
                total++;
                if (k - prev_k != prev_n + 2) begin
                    bad++;
                    $display("FAIL b2b_period%0d: got %0d, required %0d", i, k - prev_k, prev_n + 2);
                end
            end
            prev_k = k;
            prev_n = n;
        end
        for (int i = 0; i < 24; i++) begin
            total++;
            if (mem[32'h2000 + i] !== ref_rd(32'h2000 + i)) begin
                bad++;
                $display("FAIL b2b_mem %h: got %h, required %h",
                         32'h2000 + i, mem[32'h2000 + i], ref_rd(32'h2000 + i));
            end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_ctrl = 3'b000; rsp_ready = 1'b1;
        mem_rdata = 8'h00;
        test_reset;
        test_word;
        test_byte_ext;
        test_wrap;
        test_illegal;
        test_reset_mid_store;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
